// File: rtl/nec_clk_gen_if.sv
// nec_clk_gen_if: bundles the control inputs and clock/status outputs of
// nec_clk_gen. With NEC_CLK_GEN_DUTY_EN defined, a separate low-phase
// divisor (div_low) is added.
//
// Handshake: the step request is accepted on a rising clk_sys edge where
// step=1, mode=2'b10, step_busy=0 and nec_reset=0. step_busy rises on the
// next cycle and stays high until the cycle in which step_done pulses.
interface nec_clk_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 32
);
  logic [DIV_W-1:0] div_half;
`ifdef NEC_CLK_GEN_DUTY_EN
  logic [DIV_W-1:0] div_low;
`endif
  logic [1:0]       mode;
  logic             step;
  logic             nec_clk;
  logic             ce_rise;
  logic             ce_fall;
  logic             nec_reset;
  logic             running;
  logic             step_busy;
  logic             step_done;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       dbg_state;

  modport master (
`ifdef NEC_CLK_GEN_DUTY_EN
    output div_low,
`endif
    output div_half, mode, step,
    input  nec_clk, ce_rise, ce_fall, nec_reset, running,
    input  step_busy, step_done, cycle_count, dbg_state
  );

  modport slave (
`ifdef NEC_CLK_GEN_DUTY_EN
    input  div_low,
`endif
    input  div_half, mode, step,
    output nec_clk, ce_rise, ce_fall, nec_reset, running,
    output step_busy, step_done, cycle_count, dbg_state
  );
endinterface

// File: rtl/nec_clk_gen.sv
// nec_clk_gen: programmable NEC CPU clock and reset generator.
// Produces nec_clk with a runtime half-period, one-cycle rise/fall strobes,
// a post-reset hold of nec_reset for RESET_CYCLES rising edges,
// run/stop/single-step control and a free-running rising-edge counter.
// Optional macro NEC_CLK_GEN_DUTY_EN: adds div_low so the low phase can
// have its own length; otherwise both phases use div_half.
// The interface instance must use the same DIV_W/CNT_W as this module.
module nec_clk_gen #(
  parameter int DIV_W        = 8,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  nec_clk_gen_if.slave  bus
);

  // Control FSM: hold (nec_reset asserted), idle, step waiting for its
  // rise, step waiting for its fall.
  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_STEP_RISE = 2'd2,
    ST_STEP_FALL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             nec_clk_q, nec_clk_d;
  logic             ce_rise_q, ce_rise_d;
  logic             ce_fall_q, ce_fall_d;
  logic             step_done_q, step_done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic [DIV_W-1:0] phase_sel;
  logic [DIV_W-1:0] phase_last;
  logic             term;
  logic             rise_ev;
  logic             fall_ev;
  logic             hold_active;
  logic             step_busy;
  logic             rise_allow;
  logic             step_accept;

  // Length of the current phase minus one; a zero divisor counts as one.
  always_comb begin
`ifdef NEC_CLK_GEN_DUTY_EN
    phase_sel = nec_clk_q ? bus.div_half : bus.div_low;
`else
    phase_sel = bus.div_half;
`endif
    phase_last = (phase_sel == '0) ? '0 : (phase_sel - DIV_W'(1));
    term       = (cnt_q >= phase_last);
  end

  // FSM outputs: hold, busy flags and the rising-edge allow condition.
  always_comb begin
    hold_active = (state_q == ST_HOLD);
    step_busy   = (state_q == ST_STEP_RISE) || (state_q == ST_STEP_FALL);
    rise_allow  = (bus.mode == 2'b00) || hold_active || (state_q == ST_STEP_RISE);
    step_accept = bus.step && (bus.mode == 2'b10) && (state_q == ST_IDLE);
  end

  // Phase counter and edge generation; falls are never suppressed, a
  // suppressed rise parks the counter at the phase end.
  always_comb begin
    cnt_d         = cnt_q;
    nec_clk_d     = nec_clk_q;
    ce_rise_d     = 1'b0;
    ce_fall_d     = 1'b0;
    rise_ev       = 1'b0;
    fall_ev       = 1'b0;
    cycle_count_d = cycle_count_q;
    if (!term) begin
      cnt_d = cnt_q + DIV_W'(1);
    end else if (nec_clk_q) begin
      fall_ev   = 1'b1;
      nec_clk_d = 1'b0;
      ce_fall_d = 1'b1;
      cnt_d     = '0;
    end else if (rise_allow) begin
      rise_ev       = 1'b1;
      nec_clk_d     = 1'b1;
      ce_rise_d     = 1'b1;
      cnt_d         = '0;
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end else begin
      cnt_d = phase_last;
    end
  end

  // Next-state logic for the hold/step FSM.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    step_done_d = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (ce_rise_q) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          if (hold_cnt_q == 8'(RESET_CYCLES - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (step_accept) begin
          state_d = ST_STEP_RISE;
        end
      end
      ST_STEP_RISE: begin
        if (rise_ev) begin
          state_d = ST_STEP_FALL;
        end
      end
      ST_STEP_FALL: begin
        if (fall_ev) begin
          state_d     = ST_IDLE;
          step_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register with synchronous reset back into the hold.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      step_done_q <= step_done_d;
    end
  end

  // Datapath registers: phase counter, clock, strobes and edge counter.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q         <= '0;
      nec_clk_q     <= 1'b0;
      ce_rise_q     <= 1'b0;
      ce_fall_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      nec_clk_q     <= nec_clk_d;
      ce_rise_q     <= ce_rise_d;
      ce_fall_q     <= ce_fall_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.nec_clk     = nec_clk_q;
  assign bus.ce_rise     = ce_rise_q;
  assign bus.ce_fall     = ce_fall_q;
  assign bus.nec_reset   = hold_active;
  assign bus.running     = rise_allow & ~reset;
  assign bus.step_busy   = step_busy;
  assign bus.step_done   = step_done_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_nec_clk_gen.sv
// tb_nec_clk_gen: directed bench for nec_clk_gen with hand-computed
// expected waveforms; covers reset hold, divider changes, stop/run,
// single-step and reset restart (plus duty mode when the macro is set).
module tb_nec_clk_gen;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  nec_clk_gen_if #(.DIV_W(8), .CNT_W(32)) bus ();

  nec_clk_gen #(
    .DIV_W(8),
    .CNT_W(32),
    .RESET_CYCLES(16)
  ) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  // Advance one clk_sys cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   rises;
    bit   busy_seen;
    bit   found;
    logic [7:0] pat;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.div_half = 8'd2;
    bus.mode     = 2'b00;
    bus.step     = 1'b0;
`ifdef NEC_CLK_GEN_DUTY_EN
    bus.div_low  = 8'd2;
`endif

    // Reset values
    tick(); tick(); tick();
    check("rst_nec_clk", bus.nec_clk, 0);
    check("rst_ce_rise", bus.ce_rise, 0);
    check("rst_ce_fall", bus.ce_fall, 0);
    check("rst_nec_reset", bus.nec_reset, 1);
    check("rst_running", bus.running, 0);
    check("rst_step_busy", bus.step_busy, 0);
    check("rst_step_done", bus.step_done, 0);
    check("rst_cycle_count", bus.cycle_count, 0);

    // First rise H=2 cycles after reset drops, then period 4 during hold
    reset = 1'b0;
    tick();
    check("first_low", bus.nec_clk, 0);
    tick();
    check("first_rise", bus.nec_clk, 1);
    check("first_ce_rise", bus.ce_rise, 1);
    check("first_count", bus.cycle_count, 1);
    check("hold_running", bus.running, 1);
    for (int i = 0; i < 60; i++) begin
      tick();
      check("hold_clk", bus.nec_clk, ((i % 4) == 3 || (i % 4) == 0) ? 1 : 0);
      check("hold_ce_rise", bus.ce_rise, ((i % 4) == 3) ? 1 : 0);
      check("hold_ce_fall", bus.ce_fall, ((i % 4) == 1) ? 1 : 0);
      check("hold_nec_reset", bus.nec_reset, 1);
    end
    check("hold_count16", bus.cycle_count, 16);
    tick();
    check("hold_release", bus.nec_reset, 0);
    check("release_count", bus.cycle_count, 16);
    check("release_clk_high", bus.nec_clk, 1);

    // Stop while high: high phase completes, then frozen low
    bus.mode = 2'b01;
    tick();
    check("stop_fall_clk", bus.nec_clk, 0);
    check("stop_ce_fall", bus.ce_fall, 1);
    check("stop_running", bus.running, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stop_clk_low", bus.nec_clk, 0);
      check("stop_no_rise", bus.ce_rise, 0);
      check("stop_count", bus.cycle_count, 16);
    end
    bus.mode = 2'b00;
    #1;
    check("run_running", bus.running, 1);
    tick();
    check("run_rise_clk", bus.nec_clk, 1);
    check("run_ce_rise", bus.ce_rise, 1);
    check("run_count", bus.cycle_count, 17);

    // Divider change 5 -> 2 with cnt=4: toggle next cycle, then 2-cycle phases
    bus.div_half = 8'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("div5_high", bus.nec_clk, 1);
    end
    bus.div_half = 8'd2;
    tick();
    check("div2_fall", bus.nec_clk, 0);
    check("div2_ce_fall", bus.ce_fall, 1);
    tick();
    check("div2_low", bus.nec_clk, 0);
    tick();
    check("div2_rise", bus.nec_clk, 1);
    check("div2_ce_rise", bus.ce_rise, 1);
    tick();
    check("div2_high", bus.nec_clk, 1);
    tick();
    check("div2_fall2", bus.nec_clk, 0);

    // div_half 0 and 1 both give period 2
    bus.div_half = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("div0_clk", bus.nec_clk, ((i % 2) == 0) ? 1 : 0);
    end
    bus.div_half = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("div1_clk", bus.nec_clk, ((i % 2) == 0) ? 1 : 0);
    end
    check("div_count", bus.cycle_count, 22);

    // Single step with div_half=3, second pulse while busy is ignored
    bus.div_half = 8'd3;
    bus.mode     = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("step_idle_low", bus.nec_clk, 0);
      check("step_idle_running", bus.running, 0);
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check("step_busy_set", bus.step_busy, 1);
    check("step_p1_low", bus.nec_clk, 0);
    tick();
    check("step_rise", bus.nec_clk, 1);
    check("step_ce_rise", bus.ce_rise, 1);
    check("step_count", bus.cycle_count, 23);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check("step_p3_high", bus.nec_clk, 1);
    check("step_p3_busy", bus.step_busy, 1);
    tick();
    check("step_p4_high", bus.nec_clk, 1);
    check("step_p4_done", bus.step_done, 0);
    tick();
    check("step_fall", bus.nec_clk, 0);
    check("step_ce_fall", bus.ce_fall, 1);
    check("step_done", bus.step_done, 1);
    check("step_busy_clr", bus.step_busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("step_after_low", bus.nec_clk, 0);
      check("step_after_done", bus.step_done, 0);
      check("step_after_busy", bus.step_busy, 0);
    end
    check("step_count_final", bus.cycle_count, 23);

    // Reset mid-hold with step requests during the hold
    reset = 1'b1;
    tick(); tick();
    check("rst2_nec_reset", bus.nec_reset, 1);
    check("rst2_count", bus.cycle_count, 0);
    check("rst2_clk", bus.nec_clk, 0);
    reset     = 1'b0;
    bus.step  = 1'b1;
    rises     = 0;
    busy_seen = 1'b0;
    for (int n = 0; n < 400 && rises < 10; n++) begin
      tick();
      if (bus.ce_rise) rises++;
      if (bus.step_busy) busy_seen = 1'b1;
    end
    check("hold_step_rises", rises, 10);
    check("hold_step_ignored", busy_seen, 0);
    check("hold_step_reset", bus.nec_reset, 1);
    check("hold_step_count", bus.cycle_count, 10);
    bus.step = 1'b0;
    reset    = 1'b1;
    tick(); tick();
    check("rst3_count", bus.cycle_count, 0);
    check("rst3_nec_reset", bus.nec_reset, 1);
    reset = 1'b0;
    rises = 0;
    for (int n = 0; n < 400 && bus.nec_reset; n++) begin
      tick();
      if (bus.ce_rise) rises++;
    end
    check("rehold_released", bus.nec_reset, 0);
    check("rehold_rises", rises, 16);
    check("rehold_count", bus.cycle_count, 16);
    check("rehold_busy", bus.step_busy, 0);

`ifdef NEC_CLK_GEN_DUTY_EN
    // Duty mode: high 3, low 1
    bus.div_half = 8'd3;
    bus.div_low  = 8'd1;
    bus.mode     = 2'b00;
    found        = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      tick();
      if (bus.ce_rise) found = 1'b1;
    end
    check("duty_found_rise", found, 1);
    pat = 8'b11011101;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("duty_clk", bus.nec_clk, pat[7-i]);
    end
`else
    found = 1'b0;
    pat   = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nec_clk_gen.md
Name: nec_clk_gen

Overview:
- Parametrised NEC CPU clock and reset generator. It replaces the fixed clk_sys/4 free-running divider that drives NEC_CLK on the NEC bus test core.
- Provides a runtime-programmable half-period, run/stop/single-step control, and a post-reset hold of NEC_RESET for a fixed number of NEC clocks.
- Provides one-cycle rise/fall strobes in clk_sys so bus monitors sample in phase, plus a free-running NEC cycle counter.
- Sits between the top-level emu logic (OSD status, debug control) and the NEC_CLK / NEC_RESET pins.

Parameters:
- DIV_W, 8: width of the half-period divisor inputs.
- CNT_W, 32: width of cycle_count.
- RESET_CYCLES, 16: number of NEC clock rising edges during which nec_reset is held after reset deasserts; legal range 1..255.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- div_half, in, DIV_W: half-period in clk_sys cycles; H = max(div_half,1). The value 2 reproduces clk_sys/4.
- mode, in, 2: 00 run, 01 stop, 10 step, 11 treated as stop.
- step, in, 1: single-step request pulse.
- nec_clk, out, 1: clock to the NEC_CLK pin.
- ce_rise, out, 1: one-cycle strobe for a rising edge.
- ce_fall, out, 1: one-cycle strobe for a falling edge.
- nec_reset, out, 1: drives the NEC_RESET pin.
- running, out, 1: high when rising edges are currently being produced.
- step_busy, out, 1: a step is in flight.
- step_done, out, 1: one-cycle pulse when a step completes.
- cycle_count, out, CNT_W: count of NEC rising edges.

Behaviour:
- Reset values, held while reset=1:
  - nec_clk=0, ce_rise=0, ce_fall=0, nec_reset=1.
  - running=0, step_busy=0, step_done=0, cycle_count=0.
  - phase counter=0, reset-hold counter=0.
- Phase counter:
  - Counts clk_sys cycles from 0.
  - Terminal condition is cnt >= H-1, evaluated against the current div_half. A mid-phase div change therefore takes effect immediately; if cnt already exceeds the new H-1, the toggle happens on the next cycle.
  - At terminal, if the toggle is allowed: nec_clk is inverted and cnt returns to 0.
- Strobe timing: ce_rise / ce_fall are asserted in the same cycle that nec_clk first shows 1 / 0. They are registered together with nec_clk and each lasts exactly one clk_sys cycle.
- Falling edges are never suppressed; a high phase always completes.
- Rising edges are allowed when any of these holds:
  - mode==00;
  - nec_reset hold is active (mode is overridden to run);
  - step_busy=1 and the current step's rising edge has not yet been produced.
- Suppressed rising edge: nec_clk stays 0 and cnt saturates at H-1. When the rise is later allowed, it happens on the next cycle.
- running is a combinational copy of the rising-edge allow condition.
- First NEC rising edge comes H clk_sys cycles after the first cycle with reset=0.
- Reset hold:
  - After reset falls, nec_reset stays 1 and the hold counter counts ce_rise.
  - nec_reset drops to 0 in the cycle after the RESET_CYCLES-th ce_rise.
  - Re-asserting reset at any point restarts the whole sequence.
- Step:
  - A step pulse is accepted only when mode==10, step_busy==0, nec_reset==0.
  - On acceptance, step_busy goes 1 on the next cycle.
  - The step produces exactly one rising edge and one falling edge.
  - step_done pulses in the same cycle as that ce_fall, and step_busy clears in that cycle.
  - Step pulses while busy, or in any other mode, are ignored, not queued.
  - If mode leaves 10 mid-step, the step still completes.
- cycle_count increments by 1 on each ce_rise, including those in the reset hold, and wraps modulo 2^CNT_W.

Optional Feature:
- Macro: NEC_CLK_GEN_DUTY_EN.
- When defined:
  - Adds input port div_low (DIV_W).
  - div_half sets the high-phase length.
  - div_low sets the low-phase length, with L = max(div_low,1).
  - Phase select uses the current nec_clk level.
- When undefined: the port is absent and both phases use H (50% duty).

Test Plan:
- reset 3 cycles, div_half=2, mode=00 -> first nec_clk=1 two cycles after reset falls; period 4 clk_sys cycles; ce_rise every 4 cycles; nec_reset falls the cycle after the 16th ce_rise; cycle_count=16 at that point.
- div_half=0 vs div_half=1 -> both give period 2 clk_sys cycles; switch div_half 5->2 while cnt=4 -> toggle on the next cycle, then 2-cycle phases.
- After the hold, set mode=01 while nec_clk=1 -> high phase completes, ce_fall fires, nec_clk stays 0, running=0, cycle_count frozen; mode=00 -> rise one cycle later.
- mode=10, two step pulses 1 cycle apart, div_half=3 -> exactly one 6-cycle clock period, single step_done with ce_fall, cycle_count +1, second pulse ignored.
- Step pulse issued while nec_reset=1 -> ignored; reset re-asserted mid-hold after 10 rises -> nec_reset held through a fresh 16 rises, cycle_count restarts at 0.
- NEC_CLK_GEN_DUTY_EN defined, div_half=3, div_low=1 -> high for 3 cycles, low for 1 cycle, period 4.
